// File: rtl/merger_pkg.sv
// Shared constants, state encoding and width helpers for the merger-tree sorter
// and its leaf loader.
package merger_pkg;

  localparam int unsigned MERGER_DATA_WIDTH = 32;
  localparam int unsigned MERGER_TERM_VALUE = 0;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DRAIN
  } load_state_e;

  // {leaf index, word index} memory address width
  function automatic int unsigned leaf_addr_width(input int unsigned leaf_cnt,
                                                  input int unsigned len_w);
    return $clog2(leaf_cnt) + len_w;
  endfunction

  // Per-leaf slot counter must reach run_len + TERM_CNT without wrapping
  function automatic int unsigned leaf_cnt_width(input int unsigned len_w,
                                                 input int unsigned term_cnt);
    return len_w + $clog2(term_cnt) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin leaf arbiter: one grant per cycle among non-full, unfinished
// leaves, never the same leaf on two consecutive cycles.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic [N-1:0]         i_full,
  input  logic [N-1:0]         i_finished,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_grant_idx,
  output logic                 o_grant_valid
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [N-1:0]     eligible;
  logic [N-1:0]     prev_grant;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Skipping last cycle's grantee keeps an unreflected in-flight write from
  // landing on a leaf whose full flag has not caught up yet.
  assign eligible = {N{i_en}} & ~i_full & ~i_finished & ~prev_grant;

  always_comb begin
    cand        = '0;
    found       = 1'b0;
    o_grant     = '0;
    o_grant_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDX_W'((32'(last_grant) + k) % N);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        o_grant_idx = cand;
      end
    end
    o_grant[o_grant_idx] = found;
    o_grant_valid        = found;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_grant <= '0;
      last_grant <= IDX_W'(N - 1);
    end else begin
      prev_grant <= o_grant;
      if (o_grant_valid) last_grant <= o_grant_idx;
    end
  end

endmodule

// File: rtl/leaf_run_loader.sv
// Streams LEAF_CNT sorted runs from a synchronous-read memory into per-leaf
// FIFOs, appending TERM_CNT terminator words after each run.
module leaf_run_loader
  import merger_pkg::*;
#(
  parameter int unsigned            LEAF_CNT   = 256,
  parameter int unsigned            DATA_WIDTH = MERGER_DATA_WIDTH,
  parameter int unsigned            LEN_W      = 8,
  parameter int unsigned            TERM_CNT   = 4,
  parameter logic [DATA_WIDTH-1:0]  TERM_VALUE = DATA_WIDTH'(MERGER_TERM_VALUE)
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst_n,
  input  logic                                          i_start,
  input  logic [LEN_W-1:0]                              i_run_len,
  output logic                                          o_busy,
  output logic                                          o_done,
  output logic                                          o_mem_rd,
  output logic [leaf_addr_width(LEAF_CNT, LEN_W)-1:0]   o_mem_addr,
  input  logic [DATA_WIDTH-1:0]                         i_mem_data,
  input  logic [LEAF_CNT-1:0]                           i_fifo_full,
  output logic [LEAF_CNT-1:0]                           o_fifo_write,
  output logic [DATA_WIDTH-1:0]                         o_fifo_item
);

  localparam int unsigned IDX_W = $clog2(LEAF_CNT);
  localparam int unsigned CNT_W = leaf_cnt_width(LEN_W, TERM_CNT);

  load_state_e state, state_next;

  logic [LEN_W-1:0]    run_len_q;
  logic [CNT_W-1:0]    cnt [LEAF_CNT];
  logic [CNT_W-1:0]    limit;
  logic [CNT_W-1:0]    grant_cnt;
  logic [LEAF_CNT-1:0] finished;
  logic [LEAF_CNT-1:0] grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_valid;
  logic                data_slot;
  logic                start_accept;
  logic [LEAF_CNT-1:0] wr_q;
  logic                wr_data_q;

  assign start_accept = (state == LD_IDLE) && i_start;
  assign limit        = CNT_W'(run_len_q) + CNT_W'(TERM_CNT);
  assign grant_cnt    = cnt[grant_idx];
  assign data_slot    = grant_valid && (grant_cnt < CNT_W'(run_len_q));

  always_comb begin
    finished = '0;
    for (int unsigned i = 0; i < LEAF_CNT; i++) finished[i] = (cnt[i] == limit);
  end

  rr_arbiter #(.N(LEAF_CNT)) u_arb (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_en          (state == LD_LOAD),
    .i_full        (i_fifo_full),
    .i_finished    (finished),
    .o_grant       (grant),
    .o_grant_idx   (grant_idx),
    .o_grant_valid (grant_valid)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= LD_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      LD_IDLE:  if (i_start) state_next = LD_LOAD;
      LD_LOAD:  if (&finished) state_next = LD_DRAIN;
      LD_DRAIN: state_next = LD_IDLE;
      default:  state_next = LD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_len_q <= '0;
      for (int unsigned i = 0; i < LEAF_CNT; i++) cnt[i] <= '0;
    end else if (start_accept) begin
      run_len_q <= i_run_len;
      for (int unsigned i = 0; i < LEAF_CNT; i++) cnt[i] <= '0;
    end else if (grant_valid) begin
      cnt[grant_idx] <= grant_cnt + CNT_W'(1);
    end
  end

  // Write stage: the strobe is registered, the item follows the memory's
  // one-cycle read latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q      <= '0;
      wr_data_q <= 1'b0;
    end else begin
      wr_q      <= grant;
      wr_data_q <= data_slot;
    end
  end

  // Busy drops as done pulses: DRAIN is the completion cycle, not a load cycle.
  always_comb begin
    o_busy       = (state == LD_LOAD);
    o_done       = (state == LD_DRAIN);
    o_mem_rd     = data_slot;
    o_mem_addr   = data_slot ? {grant_idx, grant_cnt[LEN_W-1:0]} : '0;
    o_fifo_write = wr_q;
    o_fifo_item  = '0;
    if (|wr_q) o_fifo_item = wr_data_q ? i_mem_data : TERM_VALUE;
  end

endmodule
